two_port_ram_be: RTL and testbench

Parametrised single-clock, simple-dual-port RAM with per-byte write enables, selectable read latency (1 or 2), a read-valid strobe and optional same-cycle write-to-read forwarding. It replaces the fixed 512x1024 dual-clock buffer wherever producer and consumer share one clock domain and need partial-word updates. It serves as the standard line/tile buffer under the datapath engines.

---
 rtl/two_port_ram_be_pkg.sv | 24 ++
 rtl/two_port_ram_be_if.sv | 37 +++
 rtl/two_port_ram_be_array.sv | 43 ++++
 rtl/two_port_ram_be.sv | 156 +++++++++++++++
 tb/tb_two_port_ram_be.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/two_port_ram_be_pkg.sv
// Shared constants and helpers for the byte-enabled two-port RAM.
// Latency: n/a (package).
// Backpressure: n/a (package).
//
// Contents:
//   BYTE_W                  width of one byte lane
//   RD_LAT_MIN / RD_LAT_MAX legal range of the read latency parameter
//   merge_byte()            byte-lane merge used by the collision bypass
package two_port_ram_be_pkg;

  localparam int BYTE_W     = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Select one byte lane: the new byte when its enable is set, else the old one.
  function automatic logic [BYTE_W-1:0] merge_byte(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              sel_new
  );
    return sel_new ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/two_port_ram_be_if.sv
// Request/response bundle between a RAM user (master) and the RAM (slave).
// Latency: n/a (wires only).
// Backpressure: none; the RAM accepts a read and a write every cycle.
//
// Signals:
//   w_en, w_addr, w_be, w_data   write request (master -> slave)
//   r_en, r_addr                 read request  (master -> slave)
//   r_data, r_valid              read response (slave -> master)
interface two_port_ram_be_if
  import two_port_ram_be_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / BYTE_W
);

  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_data;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  modport master (
    output w_en, w_addr, w_be, w_data, r_en, r_addr,
    input  r_data, r_valid
  );

  modport slave (
    input  w_en, w_addr, w_be, w_data, r_en, r_addr,
    output r_data, r_valid
  );

endinterface

// File: rtl/two_port_ram_be_array.sv
// Bare byte-enabled storage array with a registered read port (block RAM style).
// Latency: read data appears in the cycle after r_en is sampled.
// Backpressure: none; r_data holds between reads. No reset anywhere.
//
// Ports:
//   clk                          clock
//   w_en, w_addr, w_be, w_data   write port, addresses assumed in range
//   r_en, r_addr, r_data         read port, address assumed in range
// A same-edge read and write to one address returns the old contents.
module ram_array_be
  import two_port_ram_be_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / BYTE_W
) (
  input  logic              clk,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [BE_W-1:0]   w_be,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_be[i]) begin
          mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (r_en) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/two_port_ram_be.sv
// Single-clock simple-dual-port RAM with byte enables, read-valid strobe and
// selectable read latency RD_LAT (1 or 2 cycles after r_en is sampled).
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset (clears output pipe only)
//   bus (slave)   w_en/w_addr/w_be/w_data, r_en/r_addr, r_data/r_valid
// Optional feature macro: TWO_PORT_RAM_BE_BYPASS_EN
//   defined     a same-cycle read/write collision returns the byte-merged word
//   undefined   a collision returns the old contents; no compare/merge logic
// Out-of-range writes are dropped; out-of-range reads return zero with r_valid.
module two_port_ram_be
  import two_port_ram_be_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W / BYTE_W,
  parameter int RD_LAT = 1
) (
  input logic              clk,
  input logic              rst,
  two_port_ram_be_if.slave bus
);

  if ((DATA_W % BYTE_W) != 0) begin : g_bad_data_w
    $error("two_port_ram_be: DATA_W=%0d is not a multiple of %0d", DATA_W, BYTE_W);
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("two_port_ram_be: RD_LAT=%0d outside %0d..%0d", RD_LAT, RD_LAT_MIN, RD_LAT_MAX);
  end

  // One extra bit so DEPTH itself is representable when it is a power of two.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic              w_in_range;
  logic              r_in_range;
  logic              arr_w_en;
  logic              arr_r_en;
  logic [DATA_W-1:0] arr_r_data;

  assign w_in_range = ({1'b0, bus.w_addr} < DEPTH_EXT);
  assign r_in_range = ({1'b0, bus.r_addr} < DEPTH_EXT);
  assign arr_w_en   = bus.w_en & w_in_range;
  // Out-of-range reads never touch the array; stage 1 substitutes zero.
  assign arr_r_en   = bus.r_en & r_in_range;

  ram_array_be #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_array (
    .clk    (clk),
    .w_en   (arr_w_en),
    .w_addr (bus.w_addr),
    .w_be   (bus.w_be),
    .w_data (bus.w_data),
    .r_en   (arr_r_en),
    .r_addr (bus.r_addr),
    .r_data (arr_r_data)
  );

  // Stage 1: control travelling alongside the array's own read register.
  logic s1_vld;
  logic s1_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_oor <= 1'b0;
    end else begin
      s1_vld <= bus.r_en;
      if (bus.r_en) begin
        s1_oor <= ~r_in_range;
      end
    end
  end

  logic [DATA_W-1:0] s1_word;

`ifdef TWO_PORT_RAM_BE_BYPASS_EN
  // The array returns old contents on a collision, so the write bytes are
  // captured here and merged over the old word once it comes out.
  logic              s1_coll;
  logic [BE_W-1:0]   s1_be;
  logic [DATA_W-1:0] s1_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_coll <= 1'b0;
    end else if (bus.r_en) begin
      s1_coll <= arr_w_en & (bus.w_addr == bus.r_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.r_en) begin
      s1_be    <= bus.w_be;
      s1_wdata <= bus.w_data;
    end
  end

  always_comb begin
    s1_word = arr_r_data;
    if (s1_coll) begin
      for (int i = 0; i < BE_W; i++) begin
        s1_word[i*BYTE_W +: BYTE_W] = merge_byte(arr_r_data[i*BYTE_W +: BYTE_W],
                                                 s1_wdata[i*BYTE_W +: BYTE_W],
                                                 s1_be[i]);
      end
    end
    if (s1_oor) begin
      s1_word = '0;
    end
  end
`else
  assign s1_word = s1_oor ? '0 : arr_r_data;
`endif

  if (RD_LAT == 1) begin : g_lat1
    // The array register is the only read stage; hold_q keeps the last word
    // visible (and resettable) once the array output moves on.
    logic [DATA_W-1:0] hold_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hold_q <= '0;
      end else if (s1_vld) begin
        hold_q <= s1_word;
      end
    end

    assign bus.r_data  = s1_vld ? s1_word : hold_q;
    assign bus.r_valid = s1_vld;
  end else begin : g_lat2
    logic              s2_vld;
    logic [DATA_W-1:0] s2_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_vld  <= 1'b0;
        s2_data <= '0;
      end else begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_data <= s1_word;
        end
      end
    end

    assign bus.r_data  = s2_data;
    assign bus.r_valid = s2_vld;
  end

endmodule

// File: tb/tb_two_port_ram_be.sv
// Bench for two_port_ram_be: one RD_LAT=1 and one RD_LAT=2 instance share the
// same stimulus; a word-level memory model predicts every response.
module tb_two_port_ram_be;
  import two_port_ram_be_pkg::*;

  localparam int DW    = 64;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int BW    = DW / 8;

  localparam logic [DW-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [DW-1:0] PAT_A = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [DW-1:0] PAT_5 = 64'h5555_5555_5555_5555;
`ifdef TWO_PORT_RAM_BE_BYPASS_EN
  localparam logic [DW-1:0] COLL_EXP = PAT_5;
`else
  localparam logic [DW-1:0] COLL_EXP = PAT_A;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  two_port_ram_be_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_a ();
  two_port_ram_be_if #(.DATA_W(DW), .DEPTH(DEPTH)) if_b ();

  assign if_b.w_en   = if_a.w_en;
  assign if_b.w_addr = if_a.w_addr;
  assign if_b.w_be   = if_a.w_be;
  assign if_b.w_data = if_a.w_data;
  assign if_b.r_en   = if_a.r_en;
  assign if_b.r_addr = if_a.r_addr;

  two_port_ram_be #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(1)) dut_l1 (
    .clk (clk), .rst (rst), .bus (if_a)
  );
  two_port_ram_be #(.DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2)) dut_l2 (
    .clk (clk), .rst (rst), .bus (if_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain word array, read result computed from the rules,
  // then shifted through a two-entry history for the two latencies.
  logic [DW-1:0] mem_m [DEPTH];
  logic          p1_v, p2_v;
  logic [DW-1:0] p1_d, p2_d, last1, last2;

  function automatic logic [DW-1:0] be_mask(input logic [BW-1:0] be);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < BW; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_reset();
    p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0; last1 = '0; last2 = '0;
  endtask

  task automatic model_edge(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                            input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] rd, m;
    m  = be_mask(be);
    rd = '0;
    if (re && int'(ra) < DEPTH) begin
      rd = mem_m[ra];
`ifdef TWO_PORT_RAM_BE_BYPASS_EN
      if (we && wa == ra) rd = (wd & m) | (rd & ~m);
`endif
    end
    if (we && int'(wa) < DEPTH) mem_m[wa] = (wd & m) | (mem_m[wa] & ~m);
    p2_v = p1_v; p2_d = p1_d;
    p1_v = re;   p1_d = rd;
    if (p1_v) last1 = p1_d;
    if (p2_v) last2 = p2_d;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    if_a.w_en = we; if_a.w_addr = wa; if_a.w_be = be; if_a.w_data = wd;
    if_a.r_en = re; if_a.r_addr = ra;
  endtask

  // One clock: apply inputs, model the edge, sample 1 time unit later.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
    drive(we, wa, be, wd, re, ra);
    @(posedge clk);
    model_edge(we, wa, be, wd, re, ra);
    #1;
    check("l1_valid", DW'(if_a.r_valid), DW'(p1_v));
    check("l1_data",  if_a.r_data, last1);
    check("l2_valid", DW'(if_b.r_valid), DW'(p2_v));
    check("l2_data",  if_b.r_data, last2);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          exp_v;
    logic          chk_d;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int cnt_a, cnt_b;
    logic we, re;
    logic [AW-1:0] wa, ra;

    tbl[0]  = '{1'b1, 10'd5,    8'hFF, ONES,  1'b0, 10'd0,    1'b0, 1'b0, '0};
    tbl[1]  = '{1'b1, 10'd5,    8'h0F, '0,    1'b0, 10'd0,    1'b0, 1'b0, '0};
    tbl[2]  = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd5,    1'b1, 1'b1, 64'hFFFF_FFFF_0000_0000};
    tbl[3]  = '{1'b1, 10'd7,    8'hFF, PAT_A, 1'b0, 10'd0,    1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000};
    tbl[4]  = '{1'b1, 10'd7,    8'hFF, PAT_5, 1'b1, 10'd7,    1'b1, 1'b1, COLL_EXP};
    tbl[5]  = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd7,    1'b1, 1'b1, PAT_5};
    tbl[6]  = '{1'b1, 10'd0,    8'hFF, 64'h1234, 1'b0, 10'd0, 1'b0, 1'b1, PAT_5};
    tbl[7]  = '{1'b1, 10'd1000, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 10'd0, 1'b0, 1'b0, '0};
    tbl[8]  = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd1000, 1'b1, 1'b1, '0};
    tbl[9]  = '{1'b1, 10'd3,    8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 10'd0, 1'b0, 1'b1, '0};
    tbl[10] = '{1'b1, 10'd3,    8'h00, ONES,  1'b0, 10'd0,    1'b0, 1'b1, '0};
    tbl[11] = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd3,    1'b1, 1'b1, 64'h0123_4567_89AB_CDEF};
    tbl[12] = '{1'b1, 10'd9,    8'hFF, 64'hCAFE_BABE_1234_5678, 1'b1, 10'd3, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF};
    tbl[13] = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd9,    1'b1, 1'b1, 64'hCAFE_BABE_1234_5678};
    tbl[14] = '{1'b0, 10'd0,    8'h00, '0,    1'b1, 10'd0,    1'b1, 1'b1, 64'h1234};

    // Reset state.
    rst = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_l1_valid", DW'(if_a.r_valid), '0);
    check("reset_l1_data",  if_a.r_data, '0);
    check("reset_l2_valid", DW'(if_b.r_valid), '0);
    check("reset_l2_data",  if_b.r_data, '0);
    rst = 1'b0;

    // Give every word a known value so all later reads are predictable.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, AW'(i), 8'hFF, {$urandom, $urandom}, 1'b0, '0);

    // Directed vectors with explicit expectations for the RD_LAT=1 instance.
    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].we, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].re, tbl[i].ra);
      check($sformatf("vec%0d_valid", i), DW'(if_a.r_valid), DW'(tbl[i].exp_v));
      if (tbl[i].chk_d) check($sformatf("vec%0d_data", i), if_a.r_data, tbl[i].exp_d);
    end

    // Idle hold after the 0x1234 read.
    for (int i = 0; i < 10; i++) begin
      idle();
      check("hold_l1_valid", DW'(if_a.r_valid), '0);
      check("hold_l1_data",  if_a.r_data, 64'h1234);
      check("hold_l2_data",  if_b.r_data, 64'h1234);
    end

    // Back-to-back reads of 0..15 after known writes.
    for (int i = 0; i < 16; i++) cycle(1'b1, AW'(i), 8'hFF, {32'(i), ~32'(i)}, 1'b0, '0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 18; i++) begin
      if (i < 16) cycle(1'b0, '0, '0, '0, 1'b1, AW'(i));
      else idle();
      if (if_a.r_valid) begin
        check("burst_l1_data", if_a.r_data, {32'(cnt_a), ~32'(cnt_a)});
        cnt_a++;
      end
      if (if_b.r_valid) begin
        check("burst_l2_data", if_b.r_data, {32'(cnt_b), ~32'(cnt_b)});
        cnt_b++;
      end
    end
    check("burst_l1_count", DW'(cnt_a), 64'd16);
    check("burst_l2_count", DW'(cnt_b), 64'd16);

    // Reset while a read is in flight in the RD_LAT=2 pipe.
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd20);
    drive(1'b0, '0, '0, '0, 1'b0, '0);
    rst = 1'b1;
    #1;
    model_reset();
    check("rstmid_l1_valid", DW'(if_a.r_valid), '0);
    check("rstmid_l1_data",  if_a.r_data, '0);
    check("rstmid_l2_valid", DW'(if_b.r_valid), '0);
    check("rstmid_l2_data",  if_b.r_data, '0);
    @(posedge clk);
    #1;
    check("rstmid_l2_valid_edge", DW'(if_b.r_valid), '0);
    check("rstmid_l2_data_edge",  if_b.r_data, '0);
    rst = 1'b0;
    idle();
    idle();
    cycle(1'b0, '0, '0, '0, 1'b1, 10'd20);
    idle();
    check("rstmid_preserved", if_b.r_data, mem_m[20]);

    // Random traffic with frequent collisions and out-of-range addresses.
    for (int i = 0; i < 600; i++) begin
      ra = (($urandom % 4) == 0) ? AW'(990 + ($urandom % 34)) : AW'($urandom % 16);
      wa = (($urandom % 5) < 2) ? ra : AW'($urandom % 16);
      we = 1'(($urandom % 3) != 0);
      re = 1'(($urandom % 3) != 0);
      cycle(we, wa, BW'($urandom), {$urandom, $urandom}, re, ra);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
